// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-line instruction cache between fetcher and memory controller.
// Hits answer one cycle after sampling; misses fetch a single word, fill the line, then answer.
module icache_direct #(
  parameter int INDEX_BITS = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush_in,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_addr,
  output logic        ins_valid,
  output logic [31:0] ins_out,
  output logic [31:0] ins_addr,
  output logic        mem_need,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_ins
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 30 - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, RESP, MISS, DROP} state_t;

  state_t      state_q, state_d;
  logic        ins_valid_q, ins_valid_d;
  logic [31:0] ins_out_q, ins_out_d;
  logic [31:0] ins_addr_q, ins_addr_d;
  logic        mem_need_q, mem_need_d;
  logic [31:0] mem_addr_q, mem_addr_d;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  logic [INDEX_BITS-1:0] fetch_idx;
  logic [TAG_W-1:0]      fetch_tag;
  logic [31:0]           fetch_aligned;
  logic                  fetch_hit;
  logic                  fill_en;
  logic [INDEX_BITS-1:0] fill_idx;
  logic [TAG_W-1:0]      fill_tag;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^fetch_addr[1:0];

  assign fetch_idx     = fetch_addr[INDEX_BITS+1:2];
  assign fetch_tag     = fetch_addr[31:INDEX_BITS+2];
  assign fetch_aligned = {fetch_addr[31:2], 2'b00};
  assign fetch_hit     = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);

  // The outstanding miss address always names the line being filled.
  assign fill_idx = mem_addr_q[INDEX_BITS+1:2];
  assign fill_tag = mem_addr_q[31:INDEX_BITS+2];

  always_comb begin
    state_d     = state_q;
    ins_valid_d = 1'b0;
    ins_out_d   = ins_out_q;
    ins_addr_d  = ins_addr_q;
    mem_need_d  = mem_need_q;
    mem_addr_d  = mem_addr_q;
    fill_en     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fetch_valid && !flush_in) begin
          if (fetch_hit) begin
            ins_out_d   = data_q[fetch_idx];
            ins_addr_d  = fetch_aligned;
            ins_valid_d = 1'b1;
            state_d     = RESP;
          end else begin
            mem_addr_d = fetch_aligned;
            mem_need_d = 1'b1;
            state_d    = MISS;
          end
        end
      end
      RESP: state_d = IDLE;
      MISS: begin
        if (mem_ready) begin
          fill_en    = 1'b1;
          mem_need_d = 1'b0;
          if (flush_in) begin
            state_d = IDLE;
          end else begin
            ins_out_d   = mem_ins;
            ins_addr_d  = mem_addr_q;
            ins_valid_d = 1'b1;
            state_d     = RESP;
          end
        end else if (flush_in) begin
          // The memory controller cannot abort, so the fill is still awaited.
          state_d = DROP;
        end
      end
      DROP: begin
        if (mem_ready) begin
          fill_en    = 1'b1;
          mem_need_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q     <= IDLE;
      ins_valid_q <= 1'b0;
      ins_out_q   <= '0;
      ins_addr_q  <= '0;
      mem_need_q  <= 1'b0;
      mem_addr_q  <= '0;
      valid_q     <= '0;
    end else if (rdy_in) begin
      state_q     <= state_d;
      ins_valid_q <= ins_valid_d;
      ins_out_q   <= ins_out_d;
      ins_addr_q  <= ins_addr_d;
      mem_need_q  <= mem_need_d;
      mem_addr_q  <= mem_addr_d;
      if (fill_en) valid_q[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in && rdy_in && fill_en) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= mem_ins;
    end
  end

  // A flush in the response cycle cancels delivery of the registered instruction.
  assign ins_valid = ins_valid_q && !flush_in;
  assign ins_out   = ins_out_q;
  assign ins_addr  = ins_addr_q;
  assign mem_need  = mem_need_q;
  assign mem_addr  = mem_addr_q;

endmodule

// File: doc/icache_direct.md
# icache_direct

Direct-mapped, one-word-per-line instruction cache between the instruction fetcher and the memory controller. On a fetch request it returns the 32-bit instruction from its tag/data arrays when the line is valid and the tag matches. On a miss it raises a word-fetch request to the memory controller, writes the returned word into the line, then answers the fetcher. A flush from branch recovery cancels delivery of a pending instruction without cancelling an in-flight memory fill.

## Interface
Parameters:
- INDEX_BITS, 4, line-index width; the cache has 2^INDEX_BITS lines of 32 bits each.

Ports:
- clk_in  input  1  system clock; all state changes on its rising edge.
- rst_in  input  1  reset, synchronous, active-low.
- rdy_in  input  1  global ready; low freezes every register and every output.
- flush_in  input  1  branch-recovery flush; suppresses any undelivered response.
- fetch_valid  input  1  fetcher request, level, held until serviced.
- fetch_addr  input  32  instruction byte address; bits [1:0] are ignored.
- ins_valid  output  1  one-cycle pulse; ins_out/ins_addr are valid.
- ins_out  output  32  instruction word.
- ins_addr  output  32  word-aligned address of ins_out.
- mem_need  output  1  miss request to the memory controller, level.
- mem_addr  output  32  word-aligned miss address, stable while mem_need is high.
- mem_ready  input  1  one-cycle pulse from the memory controller; mem_ins is valid.
- mem_ins  input  32  fetched word.

## Operation
- Address split:
  - tag = addr[31:INDEX_BITS+2].
  - index = addr[INDEX_BITS+1:2].
  - Storage: valid[2^INDEX_BITS], tag array, data array.
- States: IDLE, RESP, MISS, DROP.
- IDLE:
  - Samples the request only when fetch_valid=1 and flush_in=0.
  - Hit: register ins_out = data[index] and ins_addr = {fetch_addr[31:2],2'b00}, set ins_valid=1, go to RESP.
  - Miss: latch the aligned address into mem_addr, set mem_need=1, go to MISS.
- RESP:
  - ins_valid is high for this single cycle. No request is sampled in this cycle, so the fetcher updates fetch_addr/fetch_valid on this edge.
  - Next state is IDLE.
- MISS, on mem_ready=1:
  - Write valid/tag/data for the mem_addr index.
  - Set mem_need=0 in the same edge.
  - Set ins_out = mem_ins, ins_addr = mem_addr, ins_valid=1, and go to RESP.
  - If flush_in=1 in the same cycle as mem_ready, fill the line, assert no ins_valid, and go to IDLE.
- MISS, on flush_in=1 without mem_ready: go to DROP; mem_need stays high because the memory controller cannot abort.
- DROP, on mem_ready=1: fill the line, set mem_need=0, go to IDLE. ins_valid is never raised.
- flush_in in RESP: ins_valid is forced to 0 in that cycle and the next state is IDLE.
- Lines are never invalidated except by reset; instruction memory is read-only at run time.
- A conflict miss overwrites the line unconditionally.
- mem_ready arriving in IDLE or RESP is a protocol error and is ignored; no array write occurs.
- rdy_in=0: no state, array or output changes. A mem_ready pulse coincident with rdy_in=0 is not observed; the memory controller is frozen by the same signal.

## Timing
- Reset (rst_in=0 at an edge), required values after that edge:
  - valid[] all 0, state IDLE.
  - ins_valid=0, ins_out=0, ins_addr=0.
  - mem_need=0, mem_addr=0.
- Reset mid-miss: immediately IDLE with mem_need=0; a later stale mem_ready is ignored.
- Hit latency:
  - Request sampled at edge N; ins_valid high in cycle N+1.
  - Next request is sampled at edge N+2.
  - Peak throughput is one instruction per 2 cycles.
- Miss latency:
  - mem_need rises at edge N.
  - The mem_ready pulse at edge M drops mem_need and raises ins_valid in cycle M+1.
  - mem_need must be low by the edge after mem_ready so the memory controller's idle state does not re-issue the fetch.
- The same address re-requested after a fill hits: ins_valid follows 1 cycle after sampling.
- ins_valid is never high in two consecutive cycles.

## Test plan
- Cold miss: reset, fetch_addr=0x0000_0010, then mem_ready with mem_ins=0xDEADBEEF after 6 cycles.
  - Required: mem_need=1 with mem_addr=0x10 until mem_ready; then one ins_valid pulse with ins_out=0xDEADBEEF, ins_addr=0x10.
- Hit: re-request 0x12.
  - Required: no mem_need; ins_valid 1 cycle after sampling, ins_out=0xDEADBEEF, ins_addr=0x10.
- Conflict (INDEX_BITS=4): request 0x50 (same index as 0x10), fill 0x11111111, then request 0x10.
  - Required: the 0x10 request misses again and mem_addr=0x10.
- Flush during miss: request 0x20, assert flush_in for 1 cycle before mem_ready, then mem_ready with 0xCAFEF00D.
  - Required: no ins_valid; mem_need held until mem_ready; a later 0x20 request hits with 0xCAFEF00D.
- Stall: hold rdy_in=0 for 3 cycles across a pending hit response.
  - Required: all outputs frozen; the ins_valid pulse completes after rdy_in returns.
- Reset mid-miss: rst_in=0 while in MISS, then a spurious mem_ready.
  - Required: mem_need=0 after reset, no ins_valid, and a subsequent request for the same address misses.
